eth_udp_rx_demux: RTL and testbench
===================================

# eth_udp_rx_demux

Parametrised successor of the single-command Ethernet receive parser. It sits between the MAC receive stream and the application. It parses Ethernet/IPv4/UDP headers from a 32-bit word stream and honours the IPv4 IHL option length. It matches the UDP destination port against N_CH runtime-programmable channel ports and streams the matching payload out with backpressure, channel id and last-word byte count. Frames that fail a check are discarded and counted.

## Interface
- N_CH, 4, number of UDP port-match channels (1..16)
- CNT_W, 16, width of the statistics counters

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_self_mac  in  48  local MAC address
- i_self_ip  in  32  local IPv4 address
- i_ch_port  in  N_CH*16  UDP destination port of channel k, in bits [16k+15:16k]
- i_ch_en  in  N_CH  per-channel enable
- i_in_data  in  32  input word; word 0 = {16'h0, dst_mac[47:32]}
- i_in_sop, i_in_eop, i_in_vld  in  1  input framing/valid
- o_in_rdy  out  1  input ready
- o_out_data  out  32  payload word, first payload byte in [31:24]
- o_out_sop, o_out_eop, o_out_vld  out  1  output framing/valid
- o_out_bytes  out  3  valid bytes in the word (1..4); 4 except on eop
- o_out_ch  out  $clog2(N_CH) (min 1)  matched channel index
- o_out_err  out  1  with eop: payload truncated by early input eop
- o_out_vid  out  12  VLAN ID of the current frame (0 if untagged)
- i_out_rdy  in  1  output ready
- o_rx_frames  out  CNT_W  accepted frames (wrapping)
- o_drop_cnt  out  CNT_W  discarded frames (wrapping)

## Operation
- An input word transfers when i_in_vld && o_in_rdy. o_in_rdy = rst_n && (~o_out_vld || i_out_rdy).
- States: IDLE, ETH, VLAN (macro only), IP, IPOPT, UDP, PAY, DRAIN.
- IDLE: a transfer with sop → ETH, word 0 captured. Words without sop are ignored. A sop outside IDLE is treated as ordinary data.
- ETH, words 1-3: accept the destination MAC if it equals i_self_mac or is all-ones; otherwise → DRAIN. The type field is i_in_data[15:0] of word 3. 0x0800 → IP. 0x8100 → VLAN if the macro is defined, otherwise DRAIN. Any other type → DRAIN.
- IP, 5 words. Required checks: version 4; IHL ≥ 5; MF = 0; fragment offset 0; protocol 17; dst_ip == i_self_ip. The first failing check → DRAIN. If IHL > 5, go to IPOPT and skip IHL−5 words; then go to UDP.
- UDP, 2 words. Channel k matches when i_ch_en[k] is set and the port equals i_ch_port[k]; the lowest matching index wins. No match → DRAIN. udp_len < 8 → DRAIN. udp_len == 8: the frame is counted accepted, nothing is emitted, → DRAIN.
- PAY: payload byte count rem = udp_len − 8.
  - Each payload word is emitted with bytes = min(rem, 4), and rem decrements by 4.
  - sop is set on the first payload word. eop is set when rem ≤ 4; the block then → DRAIN (Ethernet padding is discarded).
- A frame is counted in o_rx_frames when its UDP header is accepted.
- Input eop in any state other than IDLE returns the block to IDLE.
  - Before acceptance: the frame is discarded and o_drop_cnt increments.
  - In PAY with rem > 4: that word is emitted with eop=1, err=1, bytes=min(rem,4).
  - In PAY with rem ≤ 4: normal completion.
- An input eop arriving on the same word as sop, in IDLE, counts one drop.
- Counters increment once per frame, at the deciding word, and wrap.

## Timing
- The output is one register stage. A payload word accepted on cycle n is presented on cycle n+1.
- The output is held stable while o_out_vld && ~i_out_rdy, and the input is stalled.
- Header states also stall while the output is blocked; the rule is uniform.
- Throughput is one word per cycle with no bubbles when i_out_rdy = 1.
- Reset values: all o_out_* 0; o_in_rdy 0 during reset; counters 0; state IDLE.
- Reset asserted mid-frame discards the frame silently and emits no eop. After reset, input is ignored until the next sop.
- o_out_ch and o_out_vid are constant from sop to eop.

## Configuration
- ETH_RX_VLAN_EN defined: type 0x8100 consumes one extra word, {TCI, inner_type}.
  - o_out_vid = TCI[11:0].
  - inner_type must be 0x0800, otherwise → DRAIN.
  - Only one tag is supported; inner type 0x8100 → DRAIN.
- ETH_RX_VLAN_EN undefined: 0x8100 frames are dropped and o_out_vid is tied to 0.

## Test plan
- Unicast UDP to port 0x4596 = i_ch_port[2], udp_len 14: 2 words out. The second word has bytes=2, eop=1, ch=2, err=0; o_rx_frames = 1.
- IHL=6, udp_len 16, i_out_rdy toggled 1/0 every cycle: exactly 2 payload words out, data intact, o_in_rdy follows the stall rule, the 60-byte padded frame ends with no extra words.
- Wrong dst_ip, then port matching a disabled channel, then udp_len=7: o_drop_cnt = 3, no output.
- udp_len 28 with input eop on the 3rd payload word: that word is emitted with eop=1, err=1, bytes=4.
- ETH_RX_VLAN_EN build, TCI 0x0123 and inner type 0x0800: o_out_vid = 0x123. In a build without the macro, the same frame gives o_drop_cnt +1.
- rst_n low for 1 cycle during PAY: outputs go to 0 and the counters clear. The next valid frame parses normally.

Source files
------------

// File: rtl/eth_udp_rx_demux.sv
// eth_udp_rx_demux: Ethernet/IPv4/UDP receive parser that demuxes UDP payload onto N_CH port channels.
// Define ETH_RX_VLAN_EN to accept a single 802.1Q tag and report its VLAN ID.
module eth_udp_rx_demux #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [47:0]       i_self_mac,
  input  logic [31:0]       i_self_ip,
  input  logic [N_CH*16-1:0] i_ch_port,
  input  logic [N_CH-1:0]   i_ch_en,
  input  logic [31:0]       i_in_data,
  input  logic              i_in_sop,
  input  logic              i_in_eop,
  input  logic              i_in_vld,
  output logic              o_in_rdy,
  output logic [31:0]       o_out_data,
  output logic              o_out_sop,
  output logic              o_out_eop,
  output logic              o_out_vld,
  output logic [2:0]        o_out_bytes,
  output logic [CH_W-1:0]   o_out_ch,
  output logic              o_out_err,
  output logic [11:0]       o_out_vid,
  input  logic              i_out_rdy,
  output logic [CNT_W-1:0]  o_rx_frames,
  output logic [CNT_W-1:0]  o_drop_cnt
);
  typedef enum logic [2:0] {IDLE, ETH, VLAN, IP, IPOPT, UDP, PAY, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d, ihl_q, ihl_d;
  logic [15:0]     mac_hi_q, mac_hi_d, rem_q, rem_d;
  logic [CH_W-1:0] ch_q, ch_d, out_ch_q, out_ch_d, idx;
  logic            first_q, first_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic            out_vld_q, out_vld_d, out_err_q, out_err_d;
  logic [2:0]      out_bytes_q, out_bytes_d;
  logic [CNT_W-1:0] rx_q, rx_d, drop_q, drop_d;
  logic            xfer, hit, fail, acc, drop, last;
`ifdef ETH_RX_VLAN_EN
  logic [11:0]     vid_q, vid_d, out_vid_q, out_vid_d;
`endif

  assign o_in_rdy = rst_n && (!out_vld_q || i_out_rdy);
  assign xfer     = i_in_vld && o_in_rdy;
  assign last     = rem_q <= 16'd4;

  // lowest enabled channel whose port matches wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (i_ch_en[k] && i_ch_port[16*k +: 16] == i_in_data[15:0]) begin
        hit = 1'b1;
        idx = CH_W'(k);
      end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ihl_d       = ihl_q;
    mac_hi_d    = mac_hi_q;
    rem_d       = rem_q;
    ch_d        = ch_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_err_d   = out_err_q;
    out_bytes_d = out_bytes_q;
    out_ch_d    = out_ch_q;
    out_vld_d   = o_in_rdy ? 1'b0 : out_vld_q;
`ifdef ETH_RX_VLAN_EN
    vid_d       = vid_q;
    out_vid_d   = out_vid_q;
`endif
    fail        = 1'b0;
    acc         = 1'b0;
    drop        = 1'b0;
    if (xfer) begin
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (i_in_sop) begin
            mac_hi_d = i_in_data[15:0];
            state_d  = i_in_eop ? IDLE : ETH;
            drop     = i_in_eop;
`ifdef ETH_RX_VLAN_EN
            vid_d    = '0;
`endif
          end
        end
        ETH: begin
          if (cnt_q == 4'd0 && !({mac_hi_q, i_in_data} == i_self_mac || {mac_hi_q, i_in_data} == '1))
            fail = 1'b1;
          if (cnt_q == 4'd2) begin
            cnt_d = '0;
            if (i_in_data[15:0] == 16'h0800) state_d = IP;
`ifdef ETH_RX_VLAN_EN
            else if (i_in_data[15:0] == 16'h8100) state_d = VLAN;
`endif
            else fail = 1'b1;
          end
        end
`ifdef ETH_RX_VLAN_EN
        VLAN: begin
          vid_d   = i_in_data[27:16];
          cnt_d   = '0;
          state_d = IP;
          fail    = i_in_data[15:0] != 16'h0800;
        end
`endif
        IP: begin
          if (cnt_q == 4'd0) begin
            ihl_d = i_in_data[27:24];
            fail  = i_in_data[31:28] != 4'd4 || i_in_data[27:24] < 4'd5;
          end
          if (cnt_q == 4'd1) fail = i_in_data[13] || i_in_data[12:0] != 13'd0;
          if (cnt_q == 4'd2) fail = i_in_data[23:16] != 8'd17;
          if (cnt_q == 4'd4) begin
            fail    = i_in_data != i_self_ip;
            state_d = (ihl_q > 4'd5) ? IPOPT : UDP;
            cnt_d   = '0;
          end
        end
        IPOPT: if (cnt_q == ihl_q - 4'd6) begin
          state_d = UDP;
          cnt_d   = '0;
        end
        UDP: begin
          if (cnt_q == 4'd0) begin
            ch_d = idx;
            fail = !hit;
          end else if (i_in_data[31:16] < 16'd8) fail = 1'b1;
          else begin
            acc     = 1'b1;
            rem_d   = i_in_data[31:16] - 16'd8;
            first_d = 1'b1;
            state_d = (i_in_data[31:16] == 16'd8) ? DRAIN : PAY;
            cnt_d   = '0;
          end
        end
        PAY: begin
          out_vld_d   = 1'b1;
          out_data_d  = i_in_data;
          out_sop_d   = first_q;
          out_eop_d   = last || i_in_eop;
          out_err_d   = i_in_eop && !last;
          out_bytes_d = last ? rem_q[2:0] : 3'd4;
          out_ch_d    = ch_q;
`ifdef ETH_RX_VLAN_EN
          out_vid_d   = vid_q;
`endif
          rem_d       = rem_q - 16'd4;
          first_d     = 1'b0;
          state_d     = last ? DRAIN : PAY;
        end
        default: ;
      endcase
      if (fail) begin
        state_d = DRAIN;
        drop    = 1'b1;
      end
      // early eop aborts any frame; only frames not yet accepted count as drops
      if (i_in_eop && state_q != IDLE) begin
        state_d = IDLE;
        drop    = drop || (state_q inside {ETH, VLAN, IP, IPOPT, UDP} && !acc);
      end
    end
    rx_d   = rx_q + CNT_W'(acc);
    drop_d = drop_q + CNT_W'(drop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ihl_q       <= '0;
      mac_hi_q    <= '0;
      rem_q       <= '0;
      ch_q        <= '0;
      first_q     <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_bytes_q <= '0;
      out_ch_q    <= '0;
      rx_q        <= '0;
      drop_q      <= '0;
`ifdef ETH_RX_VLAN_EN
      vid_q       <= '0;
      out_vid_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ihl_q       <= ihl_d;
      mac_hi_q    <= mac_hi_d;
      rem_q       <= rem_d;
      ch_q        <= ch_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_vld_q   <= out_vld_d;
      out_bytes_q <= out_bytes_d;
      out_ch_q    <= out_ch_d;
      rx_q        <= rx_d;
      drop_q      <= drop_d;
`ifdef ETH_RX_VLAN_EN
      vid_q       <= vid_d;
      out_vid_q   <= out_vid_d;
`endif
    end
  end

  assign o_out_data  = out_data_q;
  assign o_out_sop   = out_sop_q;
  assign o_out_eop   = out_eop_q;
  assign o_out_vld   = out_vld_q;
  assign o_out_err   = out_err_q;
  assign o_out_bytes = out_bytes_q;
  assign o_out_ch    = out_ch_q;
  assign o_rx_frames = rx_q;
  assign o_drop_cnt  = drop_q;
`ifdef ETH_RX_VLAN_EN
  assign o_out_vid   = out_vid_q;
`else
  assign o_out_vid   = 12'd0;
`endif
endmodule

// File: tb/tb_eth_udp_rx_demux.sv
// tb_eth_udp_rx_demux: directed and randomized frames checked against a byte-level frame model.
module tb_eth_udp_rx_demux;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] self_mac = 48'h0211_2233_4455;
  logic [31:0] self_ip = 32'hc0a8_0107;
  logic [63:0] ch_port = {16'h4596, 16'h4596, 16'h1234, 16'h0400};
  logic [3:0]  ch_en = 4'hf;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0, in_rdy;
  logic [31:0] out_data;
  logic        out_sop, out_eop, out_vld, out_err;
  logic [2:0]  out_bytes;
  logic [1:0]  out_ch;
  logic [11:0] out_vid;
  logic        out_rdy = 1'b1;
  logic [CNT_W-1:0] rx_frames, drop_cnt;

  int checks = 0, passed = 0, fails = 0;
  int rdy_mode = 0;
  bit gaps = 0;
  int viol_rdy = 0, viol_hold = 0;
  int rx_m = 0, drop_m = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [2:0]  b;
    logic [1:0]  c;
    logic        er;
    logic [11:0] v;
  } ow_t;
  ow_t cap[$];

  typedef struct {
    logic [47:0] dmac;
    logic [15:0] etype, tci, itype;
    logic [3:0]  ver, ihl;
    logic        mf;
    logic [12:0] foff;
    logic [7:0]  proto;
    logic [31:0] dip;
    logic [15:0] dport, ulen;
  } fr_t;

  logic [7:0]  fb[$];
  logic [7:0]  pl[$];
  logic [31:0] fw[$];
  int          pstart;

  always #5 clk = ~clk;

  eth_udp_rx_demux #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_self_mac(self_mac), .i_self_ip(self_ip),
    .i_ch_port(ch_port), .i_ch_en(ch_en), .i_in_data(in_data), .i_in_sop(in_sop),
    .i_in_eop(in_eop), .i_in_vld(in_vld), .o_in_rdy(in_rdy), .o_out_data(out_data),
    .o_out_sop(out_sop), .o_out_eop(out_eop), .o_out_vld(out_vld), .o_out_bytes(out_bytes),
    .o_out_ch(out_ch), .o_out_err(out_err), .o_out_vid(out_vid), .i_out_rdy(out_rdy),
    .o_rx_frames(rx_frames), .o_drop_cnt(drop_cnt)
  );

  initial forever begin
    @(posedge clk);
    #1;
    out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~out_rdy : 1'($urandom_range(0, 1));
  end

  // output monitor: captures transfers, watches the ready rule and hold-while-stalled
  initial begin
    ow_t w, prev_w;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      w = {out_data, out_sop, out_eop, out_bytes, out_ch, out_err, out_vid};
      if (rst_n) begin
        if (in_rdy !== (!out_vld || out_rdy)) viol_rdy++;
        if (prev_stall && (out_vld !== 1'b1 || w !== prev_w)) viol_hold++;
        if (out_vld && out_rdy) cap.push_back(w);
      end else if (in_rdy !== 1'b0) viol_rdy++;
      prev_stall = rst_n && out_vld && !out_rdy;
      prev_w = w;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic p8(input logic [7:0] b);
    fb.push_back(b);
  endtask
  task automatic p16(input logic [15:0] v);
    p8(v[15:8]); p8(v[7:0]);
  endtask
  task automatic p32(input logic [31:0] v);
    p16(v[31:16]); p16(v[15:0]);
  endtask
  task automatic p48(input logic [47:0] v);
    p16(v[47:32]); p32(v[31:0]);
  endtask

  function automatic fr_t good();
    fr_t f;
    f.dmac = self_mac; f.etype = 16'h0800; f.tci = '0; f.itype = 16'h0800;
    f.ver = 4'd4; f.ihl = 4'd5; f.mf = 1'b0; f.foff = '0; f.proto = 8'd17;
    f.dip = self_ip; f.dport = 16'h4596; f.ulen = 16'd14;
    return f;
  endfunction

  // byte image of the frame with the 2-byte alignment prefix, then packed into words
  task automatic build(input fr_t f);
    int oi;
    logic [7:0] b;
    fb.delete(); pl.delete(); fw.delete();
    oi = (f.ihl > 4'd5) ? int'(f.ihl) - 5 : 0;
    p16(16'h0); p48(f.dmac); p48({16'h0a0b, 32'($urandom)}); p16(f.etype);
    if (f.etype == 16'h8100) begin p16(f.tci); p16(f.itype); end
    p8({f.ver, f.ihl}); p8(8'h0); p16(16'(4 * f.ihl + f.ulen)); p16(16'($urandom));
    p16({2'b00, f.mf, f.foff}); p8(8'd64); p8(f.proto); p16(16'h0);
    p32($urandom); p32(f.dip);
    repeat (oi * 4) p8(8'($urandom));
    p16(16'($urandom)); p16(f.dport); p16(f.ulen); p16(16'h0);
    pstart = fb.size();
    if (f.ulen > 16'd8) repeat (int'(f.ulen) - 8) begin
      b = 8'($urandom);
      pl.push_back(b);
      p8(b);
    end
    while (fb.size() < 62) p8(8'($urandom));
    while (fb.size() % 4 != 0) p8(8'h0);
    for (int i = 0; i < fb.size(); i += 4) fw.push_back({fb[i], fb[i+1], fb[i+2], fb[i+3]});
  endtask

  task automatic drive(input int lo, input int hi, input bit sop1, input bit eop1);
    for (int i = lo; i <= hi; i++) begin
      int t;
      bit done;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_vld = 1'b0;
        @(posedge clk);
        #1;
      end
      in_data = fw[i]; in_sop = sop1 && i == lo; in_eop = eop1 && i == hi; in_vld = 1'b1;
      t = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        done = in_rdy;
        @(posedge clk);
        #1;
        t++;
        if (!done && t > 200) begin
          checks++; fails++;
          $error("FAIL drive_timeout: observed in_rdy low for %0d cycles expected transfer", t);
          done = 1'b1;
        end
      end
    end
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (out_vld && t < 300);
    if (out_vld) begin
      checks++; fails++;
      $error("FAIL drain_timeout: observed out_vld stuck 1 expected 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input fr_t f, input int n);
    bit ok, err;
    int ch, L, A, k;
    logic [11:0] vid;
    ch = -1;
    ok = (f.dmac == self_mac || f.dmac == 48'hffff_ffff_ffff) && f.ver == 4'd4 && f.ihl >= 4'd5 &&
         !f.mf && f.foff == 13'd0 && f.proto == 8'd17 && f.dip == self_ip && f.ulen >= 16'd8;
`ifdef ETH_RX_VLAN_EN
    ok = ok && (f.etype == 16'h0800 || (f.etype == 16'h8100 && f.itype == 16'h0800));
    vid = (f.etype == 16'h8100) ? f.tci[11:0] : 12'h0;
`else
    ok = ok && f.etype == 16'h0800;
    vid = 12'h0;
`endif
    for (int j = 0; j < N_CH; j++) if (ch < 0 && ch_en[j] && ch_port[16*j +: 16] == f.dport) ch = j;
    ok = ok && ch >= 0 && 4 * n >= pstart;
    if (ok) rx_m++; else drop_m++;
    L = (f.ulen > 16'd8) ? int'(f.ulen) - 8 : 0;
    A = (4 * n > pstart) ? 4 * n - pstart : 0;
    err = ok && A < L;
    k = !ok ? 0 : err ? A / 4 : (L + 3) / 4;
    chk("nwords", 64'(cap.size()), 64'(k));
    for (int i = 0; i < k && i < cap.size(); i++) begin
      int b;
      logic [31:0] ed, m;
      b = (i == k - 1 && !err) ? L - 4 * i : 4;
      ed = '0; m = '0;
      for (int j = 0; j < b; j++) begin
        ed[31-8*j -: 8] = pl[4*i+j];
        m[31-8*j -: 8] = 8'hff;
      end
      chk("data", 64'(cap[i].d & m), 64'(ed));
      chk("ctl", 64'({cap[i].s, cap[i].e, cap[i].b, cap[i].c, cap[i].er, cap[i].v}),
          64'({i == 0, i == k - 1, 3'(b), 2'(ch), err && i == k - 1, vid}));
    end
    chk("rx_frames", 64'(rx_frames), 64'(16'(rx_m)));
    chk("drop_cnt", 64'(drop_cnt), 64'(16'(drop_m)));
  endtask

  task automatic run(input fr_t f, input int cut);
    int n;
    build(f);
    n = (cut > 0 && cut < fw.size()) ? cut : fw.size();
    cap.delete();
    drive(0, n - 1, 1'b1, 1'b1);
    drain();
    check_frame(f, n);
  endtask

  initial begin
    fr_t f;
    int np;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 64'({out_vld, out_sop, out_eop, out_err, out_bytes, out_ch, out_vid}), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(0));
    chk("rst_cnt", 64'({rx_frames, drop_cnt}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    build(good());
    cap.delete();
    drive(4, 6, 1'b0, 1'b1);
    drain();
    chk("nosop_ignored", 64'({cap.size(), rx_frames, drop_cnt}), 64'(0));

    run(good(), 0);
    if (cap.size() == 2)
      chk("t1_last", 64'({cap[1].b, cap[1].e, cap[1].c, cap[1].er}), 64'({3'd2, 1'b1, 2'd2, 1'b0}));

    rdy_mode = 1;
    f = good(); f.ihl = 4'd6; f.ulen = 16'd16;
    run(f, 0);
    rdy_mode = 0;

    f = good(); f.dip = self_ip ^ 32'h1;
    run(f, 0);
    ch_en = 4'b1101;
    f = good(); f.dport = 16'h1234;
    run(f, 0);
    ch_en = 4'hf;
    f = good(); f.ulen = 16'd7;
    run(f, 0);
    chk("t3_drops", 64'(drop_cnt), 64'(3));

    f = good(); f.ulen = 16'd28;
    run(f, 14);
    if (cap.size() == 3)
      chk("t4_trunc", 64'({cap[2].e, cap[2].er, cap[2].b}), 64'({1'b1, 1'b1, 3'd4}));

    np = drop_m;
    f = good(); f.etype = 16'h8100; f.tci = 16'h0123; f.itype = 16'h0800;
    run(f, 0);
`ifdef ETH_RX_VLAN_EN
    if (cap.size() > 0) chk("t5_vid", 64'(cap[0].v), 64'(12'h123));
`else
    chk("t5_vlan_drop", 64'(drop_cnt), 64'(16'(np + 1)));
`endif

    f = good(); f.ulen = 16'd40;
    build(f);
    cap.delete();
    np = pstart / 4 + 3;
    drive(0, np - 1, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_rdy", 64'(in_rdy), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", 64'({out_vld, out_sop, out_eop, out_err, out_bytes, out_ch, out_vid, out_data}), 64'(0));
    chk("rst_mid_cnt", 64'({rx_frames, drop_cnt}), 64'(0));
    rx_m = 0; drop_m = 0;
    @(posedge clk);
    #1;
    cap.delete();
    drive(np, fw.size() - 1, 1'b0, 1'b1);
    drain();
    chk("post_rst_ignored", 64'({cap.size(), rx_frames, drop_cnt}), 64'(0));
    run(good(), 0);

    gaps = 1;
    for (int r = 0; r < 40; r++) begin
      int cut;
      f = good();
      f.ihl = 4'($urandom_range(5, 7));
      f.ulen = 16'($urandom_range(8, 40));
      case ($urandom_range(0, 2))
        0: f.dport = 16'h0400;
        1: f.dport = 16'h1234;
        default: f.dport = 16'h4596;
      endcase
      ch_en = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 14))
        1: f.dmac = self_mac ^ 48'h1;
        2: f.dmac = 48'hffff_ffff_ffff;
        3: f.dip = self_ip ^ 32'h100;
        4: f.proto = 8'd6;
        5: f.mf = 1'b1;
        6: f.foff = 13'($urandom_range(1, 100));
        7: f.dport = 16'h9999;
        8: f.ulen = 16'($urandom_range(0, 7));
        9: begin f.etype = 16'h8100; f.tci = 16'($urandom); end
        10: begin f.etype = 16'h8100; f.tci = 16'($urandom); f.itype = 16'h8100; end
        11: f.ver = 4'd6;
        12: f.ihl = 4'd4;
        13: f.etype = 16'h86dd;
        default: ;
      endcase
      rdy_mode = $urandom_range(0, 2);
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run(f, cut);
    end
    rdy_mode = 0;
    gaps = 0;

    chk("in_rdy_rule", 64'(viol_rdy), 64'(0));
    chk("hold_stable", 64'(viol_hold), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
